// File: rtl/gshare_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_btb_predictor
// Purpose  : Gshare direction predictor (2-bit counters indexed by PC xor
//            global history) combined with a direct-mapped tagged BTB.
//            Gives fetch a zero-latency taken/target guess for branch, JAL
//            and JALR instructions. Resolution from EX/MEM trains the tables
//            and repairs the speculative history on a mispredict.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            lkp_*  (in)          - fetch lookup: valid, pc, opcode
//            pred_* (out)         - taken, target, BTB hit, GHR checkpoint
//            upd_*  (in)          - resolved instruction: valid, pc, opcode,
//                                   taken, target, GHR checkpoint, mispredict
//            stat_branches (out)  - accepted updates (saturating)
//            stat_mispred  (out)  - accepted mispredicted updates (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module gshare_btb_predictor #(
    parameter int IDX_W     = 8,
    parameter int HIST_W    = 8,
    parameter int BTB_IDX_W = 6,
    parameter int TAG_W     = 10,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lkp_valid,
    input  logic [31:0]       lkp_pc,
    input  logic [6:0]        lkp_opcode,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic              pred_hit,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [6:0]        upd_opcode,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_mispredict,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_mispred
);

    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam int         c_PHT_DEPTH = 1 << IDX_W;
    localparam int         c_BTB_DEPTH = 1 << BTB_IDX_W;
    localparam int         c_TAG_LO    = BTB_IDX_W + 2;
    localparam int         c_TAG_HI    = BTB_IDX_W + TAG_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PHT_DEPTH-1:0][1:0]       r_pht_q,       w_pht_d;
    logic [c_BTB_DEPTH-1:0]            r_btb_valid_q, w_btb_valid_d;
    logic [c_BTB_DEPTH-1:0][TAG_W-1:0] r_btb_tag_q,   w_btb_tag_d;
    logic [c_BTB_DEPTH-1:0][31:0]      r_btb_tgt_q,   w_btb_tgt_d;
    logic [HIST_W-1:0]                 r_ghr_q,       w_ghr_d;
    logic [CNT_W-1:0]                  r_stat_br_q,   w_stat_br_d;
    logic [CNT_W-1:0]                  r_stat_mp_q,   w_stat_mp_d;

    // ------------------------------------------------------------------
    // Lookup side (purely combinational from lkp_* and current state)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     w_lkp_pht_idx;
    logic [BTB_IDX_W-1:0] w_lkp_btb_idx;
    logic [TAG_W-1:0]     w_lkp_tag;
    logic                 w_lkp_hit;
    logic                 w_lkp_is_br;
    logic                 w_lkp_is_jmp;
    logic [31:0]          w_lkp_seq;

    // History is zero-extended on the left before the xor
    assign w_lkp_pht_idx = lkp_pc[IDX_W+1:2] ^ IDX_W'(r_ghr_q);
    assign w_lkp_btb_idx = lkp_pc[BTB_IDX_W+1:2];
    assign w_lkp_tag     = lkp_pc[c_TAG_HI:c_TAG_LO];
    assign w_lkp_hit     = r_btb_valid_q[w_lkp_btb_idx] &&
                           (r_btb_tag_q[w_lkp_btb_idx] == w_lkp_tag);
    assign w_lkp_is_br   = (lkp_opcode == c_OP_BR);
    assign w_lkp_is_jmp  = (lkp_opcode == c_OP_JAL) || (lkp_opcode == c_OP_JALR);
    assign w_lkp_seq     = lkp_pc + 32'd4;

    always_comb begin
        pred_taken = 1'b0;
        if (lkp_valid) begin
            if (w_lkp_is_jmp) begin
                pred_taken = w_lkp_hit;
            end else if (w_lkp_is_br) begin
                pred_taken = w_lkp_hit & r_pht_q[w_lkp_pht_idx][1];
            end
        end
        pred_target = pred_taken ? r_btb_tgt_q[w_lkp_btb_idx] : w_lkp_seq;
    end

    assign pred_hit      = w_lkp_hit;
    assign pred_ghr      = r_ghr_q;
    assign stat_branches = r_stat_br_q;
    assign stat_mispred  = r_stat_mp_q;

    // ------------------------------------------------------------------
    // History shift values; a one-bit history has no older bits to keep
    // ------------------------------------------------------------------
    logic [HIST_W-1:0] w_ghr_spec;
    logic [HIST_W-1:0] w_ghr_rec_br;

    generate
        if (HIST_W == 1) begin : g_hist_one
            assign w_ghr_spec   = pred_taken;
            assign w_ghr_rec_br = upd_taken;
        end else begin : g_hist_multi
            assign w_ghr_spec   = {r_ghr_q[HIST_W-2:0], pred_taken};
            assign w_ghr_rec_br = {upd_ghr[HIST_W-2:0], upd_taken};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Update side
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     w_upd_pht_idx;
    logic [BTB_IDX_W-1:0] w_upd_btb_idx;
    logic                 w_upd_is_br;
    logic                 w_upd_ctl;
    logic [1:0]           w_upd_cnt;
    logic                 w_unused_upd;

    // The checkpoint, not the live GHR, rebuilds the index the lookup used
    assign w_upd_pht_idx = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
    assign w_upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
    assign w_upd_is_br   = (upd_opcode == c_OP_BR);
    assign w_upd_ctl     = upd_valid && (w_upd_is_br ||
                           (upd_opcode == c_OP_JAL) || (upd_opcode == c_OP_JALR));
    assign w_upd_cnt     = r_pht_q[w_upd_pht_idx];
    // Low alignment bits and bits above the tag carry no predictor state
    assign w_unused_upd  = ^upd_pc;

    always_comb begin
        w_pht_d       = r_pht_q;
        w_btb_valid_d = r_btb_valid_q;
        w_btb_tag_d   = r_btb_tag_q;
        w_btb_tgt_d   = r_btb_tgt_q;
        w_ghr_d       = r_ghr_q;
        w_stat_br_d   = r_stat_br_q;
        w_stat_mp_d   = r_stat_mp_q;

        if (lkp_valid && w_lkp_is_br) begin
            w_ghr_d = w_ghr_spec;
        end

        if (w_upd_ctl) begin
            if (w_upd_is_br) begin
                if (upd_taken && (w_upd_cnt != 2'b11)) begin
                    w_pht_d[w_upd_pht_idx] = w_upd_cnt + 2'd1;
                end else if (!upd_taken && (w_upd_cnt != 2'b00)) begin
                    w_pht_d[w_upd_pht_idx] = w_upd_cnt - 2'd1;
                end
            end
            if (upd_taken) begin
                w_btb_valid_d[w_upd_btb_idx] = 1'b1;
                w_btb_tag_d[w_upd_btb_idx]   = upd_pc[c_TAG_HI:c_TAG_LO];
                w_btb_tgt_d[w_upd_btb_idx]   = upd_target;
            end
            if (r_stat_br_q != {CNT_W{1'b1}}) begin
                w_stat_br_d = r_stat_br_q + CNT_W'(1);
            end
            if (upd_mispredict && (r_stat_mp_q != {CNT_W{1'b1}})) begin
                w_stat_mp_d = r_stat_mp_q + CNT_W'(1);
            end
            // Repair overrides any speculative shift made this cycle
            if (upd_mispredict) begin
                w_ghr_d = w_upd_is_br ? w_ghr_rec_br : upd_ghr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pht_q       <= {c_PHT_DEPTH{2'b01}};
            r_btb_valid_q <= '0;
            r_ghr_q       <= '0;
            r_stat_br_q   <= '0;
            r_stat_mp_q   <= '0;
        end else begin
            r_pht_q       <= w_pht_d;
            r_btb_valid_q <= w_btb_valid_d;
            r_ghr_q       <= w_ghr_d;
            r_stat_br_q   <= w_stat_br_d;
            r_stat_mp_q   <= w_stat_mp_d;
        end
    end

    // Tag/target need no reset: they are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btb_tag_q <= w_btb_tag_d;
            r_btb_tgt_q <= w_btb_tgt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_btb_predictor
// Purpose  : Self-checking bench for gshare_btb_predictor. An integer-level
//            model of the tables is compared with the DUT on every cycle, and
//            directed scenarios pin the model with literal expectations. A
//            second instance with 4-bit counters exercises stat saturation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_btb_predictor;

    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_ADDI = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        lkp_valid;
    logic [31:0] lkp_pc;
    logic [6:0]  lkp_opcode;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [6:0]  upd_opcode;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_ghr;
    logic        upd_mispredict;

    logic        pred_taken, pred_hit;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic [31:0] stat_branches, stat_mispred;

    logic        s_taken, s_hit;
    logic [31:0] s_target;
    logic [7:0]  s_ghr;
    logic [3:0]  s_branches, s_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gshare_btb_predictor u_dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_pc(lkp_pc), .lkp_opcode(lkp_opcode),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_hit(pred_hit), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_opcode(upd_opcode),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    gshare_btb_predictor #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_pc(lkp_pc), .lkp_opcode(lkp_opcode),
        .pred_taken(s_taken), .pred_target(s_target),
        .pred_hit(s_hit), .pred_ghr(s_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_opcode(upd_opcode),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict),
        .stat_branches(s_branches), .stat_mispred(s_mispred)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain integer tables
    // ------------------------------------------------------------------
    int          m_pht [256];
    bit          m_v   [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ghr;
    longint      m_nb, m_nm;
    bit          m_ok = 1'b0;

    function automatic bit is_ctl(input logic [6:0] op);
        return (op == c_OP_BR) || (op == c_OP_JAL) || (op == c_OP_JALR);
    endfunction

    function automatic void m_pred(input logic v, input logic [31:0] pc, input logic [6:0] op,
                                   output bit hit, output bit tk, output logic [31:0] tgt);
        int bi, tg, pi;
        bi  = int'((pc >> 2) % 32'd64);
        tg  = int'((pc >> 8) % 32'd1024);
        pi  = int'((pc >> 2) % 32'd256) ^ m_ghr;
        hit = m_v[bi] && (m_tag[bi] == tg);
        tk  = 1'b0;
        if (v) begin
            if (op == c_OP_JAL || op == c_OP_JALR) tk = hit;
            else if (op == c_OP_BR)                tk = hit && (m_pht[pi] >= 2);
        end
        tgt = tk ? m_tgt[bi] : pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        bit          h, t;
        logic [31:0] g;
        int          ng, pi, bi;
        if (rst) begin
            for (int i = 0; i < 256; i++) m_pht[i] = 1;
            for (int i = 0; i < 64; i++)  m_v[i]   = 1'b0;
            m_ghr = 0;
            m_nb  = 0;
            m_nm  = 0;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            m_pred(lkp_valid, lkp_pc, lkp_opcode, h, t, g);
            ng = m_ghr;
            if (lkp_valid && lkp_opcode == c_OP_BR) ng = (m_ghr * 2 + int'(t)) % 256;
            if (upd_valid && is_ctl(upd_opcode)) begin
                if (upd_opcode == c_OP_BR) begin
                    pi = int'((upd_pc >> 2) % 32'd256) ^ int'(upd_ghr);
                    if (upd_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
                    else           m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
                end
                if (upd_taken) begin
                    bi        = int'((upd_pc >> 2) % 32'd64);
                    m_v[bi]   = 1'b1;
                    m_tag[bi] = int'((upd_pc >> 8) % 32'd1024);
                    m_tgt[bi] = upd_target;
                end
                m_nb++;
                if (upd_mispredict) m_nm++;
                if (upd_mispredict)
                    ng = (upd_opcode == c_OP_BR) ? (int'(upd_ghr) * 2 + int'(upd_taken)) % 256
                                                 : int'(upd_ghr);
            end
            m_ghr = ng;
        end
    end

    // Cycle-by-cycle compare against the model, mid-cycle
    always @(negedge clk) begin
        bit          h, t;
        logic [31:0] g;
        if (m_ok && !rst) begin
            m_pred(lkp_valid, lkp_pc, lkp_opcode, h, t, g);
            chk("mdl_taken",    pred_taken,    t);
            chk("mdl_hit",      pred_hit,      h);
            chk("mdl_target",   pred_target,   g);
            chk("mdl_ghr",      pred_ghr,      m_ghr[7:0]);
            chk("mdl_branches", stat_branches, m_nb[31:0]);
            chk("mdl_mispred",  stat_mispred,  m_nm[31:0]);
            chk("mdl_sat_taken",    s_taken,    t);
            chk("mdl_sat_branches", s_branches, (m_nb > 15) ? 64'd15 : m_nb);
            chk("mdl_sat_mispred",  s_mispred,  (m_nm > 15) ? 64'd15 : m_nm);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        lkp_valid = 1'b0; lkp_pc = 32'h0; lkp_opcode = 7'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_opcode = 7'h0;
        upd_taken = 1'b0; upd_target = 32'h0; upd_ghr = 8'h0; upd_mispredict = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic lkp(input logic [31:0] pc, input logic [6:0] op);
        lkp_valid = 1'b1; lkp_pc = pc; lkp_opcode = op;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [6:0] op, input logic tk,
                       input logic [31:0] tgt, input logic [7:0] ghr, input logic mp);
        upd_valid = 1'b1; upd_pc = pc; upd_opcode = op; upd_taken = tk;
        upd_target = tgt; upd_ghr = ghr; upd_mispredict = mp;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;

        // 1: post-reset lookup
        lkp(32'h100, c_OP_BR);
        @(negedge clk);
        chk("t1_taken",  pred_taken,  0);
        chk("t1_hit",    pred_hit,    0);
        chk("t1_target", pred_target, 32'h104);
        chk("t1_ghr",    pred_ghr,    0);
        tick();
        lkp(32'hFFFF_FFFC, c_OP_ADDI);
        @(negedge clk);
        chk("t1_wrap_target", pred_target, 32'h0);
        tick();

        // 2: JAL install, no same-cycle bypass, alias miss
        upd(32'h200, c_OP_JAL, 1'b1, 32'h400, 8'h0, 1'b1);
        lkp(32'h200, c_OP_JAL);
        @(negedge clk);
        chk("t2_nobypass_hit", pred_hit, 0);
        tick();
        lkp(32'h200, c_OP_JAL);
        @(negedge clk);
        chk("t2_hit",    pred_hit,    1);
        chk("t2_taken",  pred_taken,  1);
        chk("t2_target", pred_target, 32'h400);
        tick();
        lkp(32'h300, c_OP_JAL);
        @(negedge clk);
        chk("t2_alias_hit",    pred_hit,    0);
        chk("t2_alias_target", pred_target, 32'h304);
        tick();

        // 3: counter saturation at both ends
        repeat (3) begin upd(32'h80, c_OP_BR, 1'b1, 32'h40, 8'h0, 1'b0); tick(); end
        upd(32'h80, c_OP_BR, 1'b0, 32'h84, 8'h0, 1'b0); tick();
        lkp(32'h80, c_OP_BR);                              // counter now 2
        upd(32'h900, c_OP_JAL, 1'b1, 32'h910, 8'h0, 1'b1); // repair GHR to 0
        @(negedge clk);
        chk("t3_mid_taken",  pred_taken,  1);
        chk("t3_mid_target", pred_target, 32'h40);
        tick();
        repeat (2) begin upd(32'h80, c_OP_BR, 1'b0, 32'h84, 8'h0, 1'b0); tick(); end
        lkp(32'h80, c_OP_BR);
        @(negedge clk);
        chk("t3_hit",    pred_hit,    1);
        chk("t3_taken",  pred_taken,  0);
        chk("t3_target", pred_target, 32'h84);
        chk("t3_ghr",    pred_ghr,    0);
        tick();

        // 4: speculative history T,N,T then repair
        repeat (2) begin upd(32'hC0, c_OP_BR, 1'b1, 32'h500, 8'h0, 1'b0); tick(); end
        repeat (2) begin upd(32'hD0, c_OP_BR, 1'b1, 32'h600, 8'h2, 1'b0); tick(); end
        lkp(32'hC0, c_OP_BR);
        @(negedge clk);
        chk("t4_p1_taken", pred_taken, 1);
        tick();
        lkp(32'hE0, c_OP_BR);
        @(negedge clk);
        chk("t4_p2_taken", pred_taken, 0);
        chk("t4_p2_ghr",   pred_ghr,   8'h01);
        tick();
        lkp(32'hD0, c_OP_BR);
        @(negedge clk);
        chk("t4_p3_taken",  pred_taken,  1);
        chk("t4_p3_target", pred_target, 32'h600);
        tick();
        lkp(32'hC0, c_OP_BR);
        upd(32'hC0, c_OP_BR, 1'b0, 32'hC4, 8'h0, 1'b1);
        @(negedge clk);
        chk("t4_ghr_101", pred_ghr, 8'h05);
        tick();
        @(negedge clk);
        chk("t4_ghr_repaired", pred_ghr, 8'h00);
        tick();

        // 5: reset mid-stream
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            upd(32'h2000 + 32'(i * 4), c_OP_JAL, 1'b1, 32'h3000 + 32'(i * 16), 8'h0, i < 4);
            tick();
        end
        lkp(32'h2008, c_OP_JAL);
        @(negedge clk);
        chk("t5_pre_hit",      pred_hit,      1);
        chk("t5_pre_target",   pred_target,   32'h3020);
        chk("t5_pre_branches", stat_branches, 10);
        chk("t5_pre_mispred",  stat_mispred,  4);
        tick();
        rst = 1'b1;
        lkp(32'h2008, c_OP_JAL);
        upd(32'h2008, c_OP_JAL, 1'b1, 32'h3020, 8'h0, 1'b1);
        tick();
        rst = 1'b0;
        lkp(32'h2008, c_OP_JAL);
        @(negedge clk);
        chk("t5_post_hit",      pred_hit,      0);
        chk("t5_post_target",   pred_target,   32'h200C);
        chk("t5_post_branches", stat_branches, 0);
        chk("t5_post_mispred",  stat_mispred,  0);
        tick();

        // 6: statistics saturation on the narrow instance
        repeat (20) begin upd(32'h40, c_OP_BR, 1'b0, 32'h44, 8'h0, 1'b0); tick(); end
        @(negedge clk);
        chk("t6_sat_branches",  s_branches,    4'hF);
        chk("t6_sat_mispred",   s_mispred,     4'h0);
        chk("t6_wide_branches", stat_branches, 20);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
